// File: rtl/pc_branch_ctrl_pkg.sv
// rtl/pc_branch_ctrl_pkg.sv - shared opcode, condition-code and FSM state definitions
package pc_branch_ctrl_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// rtl/pc_branch_ctrl_if.sv - fetch/ALU-flag/PC bundle between core pipeline and branch control
interface pc_branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      instr;
  logic             stall;
  logic             n_flag;
  logic             z_flag;
  logic             v_flag;
  logic [15:0]      rs_data;
  logic [15:0]      pc;
  logic [15:0]      pc_plus2;
  logic             taken;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  modport master (
    output instr, stall, n_flag, z_flag, v_flag, rs_data,
    input  pc, pc_plus2, taken, flush, halted, br_total, br_taken
  );

  modport slave (
    input  instr, stall, n_flag, z_flag, v_flag, rs_data,
    output pc, pc_plus2, taken, flush, halted, br_total, br_taken
  );
endinterface

// File: rtl/pc_branch_ctrl_branch_cond.sv
// rtl/pc_branch_ctrl_branch_cond.sv - combinational condition-code evaluation from N/Z/V
module pc_branch_ctrl_branch_cond
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       v_flag,
  output logic       cond_met
);
  always_comb begin
    cond_met = 1'b0;
    case (ccc)
      CC_NE: cond_met = ~z_flag;
      CC_EQ: cond_met = z_flag;
      CC_GT: cond_met = ~z_flag & ~n_flag;
      CC_LT: cond_met = n_flag;
      CC_GE: cond_met = z_flag | (~z_flag & ~n_flag);
      CC_LE: cond_met = n_flag | z_flag;
      CC_OV: cond_met = v_flag;
      CC_UN: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end
endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, branch resolution, halt FSM and branch statistics
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  pc_branch_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic             flush_q;
  logic [CNT_W-1:0] total_q, taken_cnt_q;

  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic        cond_met, is_branch, taken, advance;
  logic [15:0] pc_plus2, b_target;

  assign opcode = bus.instr[15:12];
  assign ccc    = bus.instr[11:9];
  assign imm9   = bus.instr[8:0];

  pc_branch_ctrl_branch_cond u_cond (
    .ccc      (ccc),
    .n_flag   (bus.n_flag),
    .z_flag   (bus.z_flag),
    .v_flag   (bus.v_flag),
    .cond_met (cond_met)
  );

  assign is_branch = (opcode == OP_B) | (opcode == OP_BR);
  assign taken     = is_branch & cond_met;
  assign pc_plus2  = pc_q + 16'd2;
  // Halfword offset: sign-extended imm9 shifted left by one.
  assign b_target  = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
  assign advance   = (state_q == RUN) & ~bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (advance) begin
      if (opcode == OP_HLT) begin
        state_d = HALTED;
        pc_d    = pc_q;
      end else if (taken && opcode == OP_B) begin
        pc_d = b_target;
      end else if (taken && opcode == OP_BR) begin
        pc_d = bus.rs_data;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      total_q     <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= advance & taken;
      if (advance && is_branch) begin
        if (total_q != CNT_MAX) total_q <= total_q + CNT_ONE;
        if (taken && taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus2 = pc_plus2;
  assign bus.taken    = taken;
  assign bus.flush    = flush_q;
  assign bus.halted   = (state_q == HALTED);
  assign bus.br_total = total_q;
  assign bus.br_taken = taken_cnt_q;
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - randomized self-checking bench for pc_branch_ctrl
module tb_pc_branch_ctrl;
  import pc_branch_ctrl_pkg::*;

  localparam int CW     = 8;
  localparam int CMAX_I = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_pc;
  logic        m_halted;
  logic        m_flush;
  int          m_tot;
  int          m_tkn;

  pc_branch_ctrl_if #(.CNT_W(CW)) bus ();

  pc_branch_ctrl #(.RESET_PC(16'h0000), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [2:0] c, input logic n, input logic z, input logic v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] c, input logic [8:0] imm);
    return {op, c, imm};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_halted = 1'b0; m_flush = 1'b0; m_tot = 0; m_tkn = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_pc"},     bus.pc,       m_pc);
    check({tag, "_flush"},  bus.flush,    m_flush);
    check({tag, "_halted"}, bus.halted,   m_halted);
    check({tag, "_total"},  bus.br_total, m_tot);
    check({tag, "_taken"},  bus.br_taken, m_tkn);
  endtask

  // One instruction slot: drive at negedge, check combinational outputs, clock, check state.
  task automatic step(input logic [15:0] ins, input logic stl, input logic n, input logic z,
                      input logic v, input logic [15:0] rs);
    logic [3:0] op;
    logic       tk, adv, isbr;
    int         off;
    bus.instr = ins; bus.stall = stl; bus.n_flag = n; bus.z_flag = z; bus.v_flag = v;
    bus.rs_data = rs;
    #1;
    op   = ins[15:12];
    isbr = (op == 4'hC) || (op == 4'hD);
    tk   = isbr && cond_ref(ins[11:9], n, z, v);
    check("taken", bus.taken, tk);
    check("pc_plus2", bus.pc_plus2, 16'(m_pc + 16'd2));
    adv = !stl && !m_halted;
    m_flush = adv && tk;
    if (adv) begin
      off = int'($signed(ins[8:0])) * 2;
      if (op == 4'hF) m_halted = 1'b1;
      else if (tk && op == 4'hC) m_pc = 16'(int'(m_pc) + 2 + off);
      else if (tk && op == 4'hD) m_pc = rs;
      else m_pc = 16'(int'(m_pc) + 2);
      if (isbr) begin
        if (m_tot < CMAX_I) m_tot++;
        if (tk && m_tkn < CMAX_I) m_tkn++;
      end
    end
    @(posedge clk);
    #1;
    check_regs("step");
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    bus.instr = 16'h0; bus.stall = 1'b0; bus.n_flag = 1'b0; bus.z_flag = 1'b0;
    bus.v_flag = 1'b0; bus.rs_data = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs("reset");
    rst_n = 1'b1;

    repeat (4) step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("seq_pc", bus.pc, 16'h0008);

    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
    step(mk(OP_B, CC_EQ, 9'h1FE), 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("beq_pc", bus.pc, 16'h000E);
    check("beq_flush", bus.flush, 1'b1);
    step(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
    step(mk(OP_B, CC_EQ, 9'h1FE), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("bne_pc", bus.pc, 16'h0012);

    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        step(mk(OP_B, 3'(c), 9'($urandom)), 1'b1, f[2], f[1], f[0], 16'($urandom));

    step(mk(OP_BR, CC_UN, 9'h0), 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD);
    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD);
    check("br_pc", bus.pc, 16'hABCD);

    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);
    async_reset();

    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      if (r[15:12] == 4'hF) r[15:12] = 4'hE;
      if (i % 3 == 0) r[15:13] = 3'b110;
      step(r, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom));
    end

    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_pc", bus.pc, 16'h0000);

    repeat (CMAX_I + 5) step(mk(OP_B, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("sat_total", bus.br_total, CMAX_I);
    check("sat_taken", bus.br_taken, CMAX_I);

    step(mk(OP_BR, CC_UN, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020);
    step(mk(OP_HLT, 3'd0, 9'h0), 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("hlt_stall", bus.halted, 1'b0);
    step(mk(OP_HLT, 3'd0, 9'h0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (10) step(mk(OP_B, CC_UN, 9'($urandom)), 1'($urandom), 1'b0, 1'b0, 1'b0,
                     16'($urandom));
    check("hlt_pc", bus.pc, 16'h0020);
    check("hlt_flag", bus.halted, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
